// File: rtl/cnn_result_argmax_if.sv
// cnn_result_argmax_if: five score stream sinks, one result stream source, plus status.
interface cnn_result_argmax_if #(
   parameter int DATA_WIDTH  = 12,
   parameter int COUNT_WIDTH = 16
);
   logic [DATA_WIDTH-1:0]  score_TDATA [5];
   logic [4:0]             score_TVALID;
   logic [4:0]             score_TREADY;
   logic [DATA_WIDTH+2:0]  result_TDATA;
   logic                   result_TVALID;
   logic                   result_TREADY;
   logic [COUNT_WIDTH-1:0] frame_count;
   logic                   busy;
   modport master (
      output score_TDATA, score_TVALID, result_TREADY,
      input  score_TREADY, result_TDATA, result_TVALID, frame_count, busy
   );
   modport slave (
      input  score_TDATA, score_TVALID, result_TREADY,
      output score_TREADY, result_TDATA, result_TVALID, frame_count, busy
   );
endinterface

// File: rtl/cnn_result_argmax.sv
// cnn_result_argmax: collects one score per class, then a 4-step signed argmax and one result beat.
module cnn_result_argmax #(
   parameter int                           DATA_WIDTH      = 12,
   parameter logic signed [DATA_WIDTH-1:0] SCORE_THRESHOLD = '0,
   parameter int                           COUNT_WIDTH     = 16
) (
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   cnn_result_argmax_if.slave  s
);
   typedef enum logic [1:0] {COLLECT, SCAN, EMIT} state_t;
   state_t                       state_q, state_d;
   logic [DATA_WIDTH-1:0]        slot_q [5];
   logic [DATA_WIDTH-1:0]        slot_d [5];
   logic [4:0]                   full_q, full_d, tready_q, tready_d, hs;
   logic signed [DATA_WIDTH-1:0] best_q, best_d;
   logic [2:0]                   idx_q, idx_d, k_q, k_d;
   logic                         valid_q, valid_d, busy_q, busy_d;
   logic [DATA_WIDTH+2:0]        data_q, data_d;
   logic [COUNT_WIDTH-1:0]       count_q, count_d;
   always_comb begin
      hs      = s.score_TVALID & tready_q;
      state_d = state_q;
      full_d  = full_q;
      best_d  = best_q;
      idx_d   = idx_q;
      k_d     = k_q;
      valid_d = valid_q;
      data_d  = data_q;
      count_d = count_q;
      for (int i = 0; i < 5; i++) slot_d[i] = hs[i] ? s.score_TDATA[i] : slot_q[i];
      if (state_q == COLLECT) begin
         full_d = full_q | hs;
         if (&full_d) begin
            state_d = SCAN;
            best_d  = slot_d[0];
            idx_d   = 3'd0;
            k_d     = 3'd1;
         end
      end else if (state_q == SCAN) begin
         // strict compare keeps the lowest index on ties
         if ($signed(slot_q[k_q]) > best_q) begin
            best_d = slot_q[k_q];
            idx_d  = k_q;
         end
         k_d = k_q + 3'd1;
         if (k_q == 3'd4) begin
            state_d = EMIT;
            valid_d = 1'b1;
            data_d  = {((best_d < SCORE_THRESHOLD) ? 3'd7 : idx_d), best_d};
         end
      end else if (s.result_TREADY) begin
         state_d = COLLECT;
         valid_d = 1'b0;
         data_d  = '0;
         full_d  = '0;
         count_d = count_q + COUNT_WIDTH'(1);
      end
      tready_d = (state_d == COLLECT) ? ~full_d : 5'h00;
      busy_d   = state_d != COLLECT;
   end
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q  <= COLLECT;
         slot_q   <= '{default: '0};
         full_q   <= '0;
         tready_q <= 5'h1F;
         best_q   <= '0;
         idx_q    <= '0;
         k_q      <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         data_q   <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         full_q   <= full_d;
         tready_q <= tready_d;
         best_q   <= best_d;
         idx_q    <= idx_d;
         k_q      <= k_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         data_q   <= data_d;
         count_q  <= count_d;
      end
   end
   assign s.score_TREADY  = tready_q;
   assign s.result_TVALID = valid_q;
   assign s.result_TDATA  = data_q;
   assign s.frame_count   = count_q;
   assign s.busy          = busy_q;
endmodule
